// File: rtl/hilo_seq_ctrl_if.sv
// Decode-side request/read-stall handshake plus the command bundle that drives the HI/LO unit.
// The master modport is the decode/pipeline side; the slave modport is the sequencer.
interface hilo_seq_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        rd_req;
    logic        stall;
    logic        busy;
    logic        div_zero;
    logic        unit_write_en;
    logic [1:0]  unit_op;
    logic        unit_sin;
    logic [31:0] unit_in_1;
    logic [31:0] unit_in_2;

    modport master (
        output req_valid, req_op, req_a, req_b, flush, rd_req,
        input  req_ready, stall, busy, div_zero,
        input  unit_write_en, unit_op, unit_sin, unit_in_1, unit_in_2
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush, rd_req,
        output req_ready, stall, busy, div_zero,
        output unit_write_en, unit_op, unit_sin, unit_in_1, unit_in_2
    );
endinterface

// File: rtl/hilo_seq_ctrl.sv
// Sequencer in front of the HI/LO unit: accepts one HI/LO-writing op, waits out the
// multiply/divide latency, then issues a single-cycle write and stalls MFHI/MFLO until then.
module hilo_seq_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic            clk,
    input  logic            reset,
    hilo_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam logic [5:0] MULT_CNT = 6'(MULT_LAT - 1);
    localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT - 1);

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [1:0]  op_q;
    logic        sin_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        wen_q;
    logic        dz_q;

    logic [1:0]  op_d;
    logic        sin_d;
    logic        long_d;
    logic        legal_d;
    logic [5:0]  cnt_d;

    always_comb begin
        op_d    = 2'b00;
        sin_d   = 1'b0;
        long_d  = 1'b0;
        legal_d = 1'b1;
        cnt_d   = 6'd0;
        unique case (bus.req_op)
            3'b000: op_d = 2'b00;
            3'b001: op_d = 2'b01;
            3'b010, 3'b011: begin
                op_d   = 2'b10;
                sin_d  = bus.req_op[0];
                long_d = 1'b1;
                cnt_d  = MULT_CNT;
            end
            3'b100, 3'b101: begin
                op_d   = 2'b11;
                sin_d  = bus.req_op[0];
                long_d = 1'b1;
                cnt_d  = DIV_CNT;
            end
            default: legal_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 2'b00;
            sin_q   <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            wen_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Illegal ops are consumed here and never reach the unit.
                    if (bus.req_valid && legal_d) begin
                        op_q  <= op_d;
                        sin_q <= sin_d;
                        a_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        if (long_d) begin
                            state_q <= WAIT;
                            cnt_q   <= cnt_d;
                        end else begin
                            state_q <= COMMIT;
                            wen_q   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 6'd0) begin
                        state_q <= COMMIT;
                        // A zero divisor turns the commit into a div_zero report instead of a write.
                        if (op_q == 2'b11 && b_q == 32'd0) begin
                            dz_q <= 1'b1;
                        end else begin
                            wen_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                COMMIT: begin
                    state_q <= IDLE;
                    wen_q   <= 1'b0;
                    dz_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    wen_q   <= 1'b0;
                    dz_q    <= 1'b0;
                end
            endcase
        end
    end

    // COMMIT stalls too: HI/LO only takes the new value at the end of that cycle.
    assign bus.req_ready     = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.stall         = bus.rd_req && (state_q != IDLE);
    assign bus.div_zero      = dz_q;
    assign bus.unit_write_en = wen_q;
    assign bus.unit_op       = op_q;
    assign bus.unit_sin      = sin_q;
    assign bus.unit_in_1     = a_q;
    assign bus.unit_in_2     = b_q;

endmodule

// File: tb/tb_hilo_seq_ctrl.sv
// Self-checking bench: vector table, hand-written corner sequences and random traffic,
// all checked cycle by cycle against a cycle-count reference model and a HI/LO unit stub.
module tb_hilo_seq_ctrl;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hilo_seq_ctrl_if m ();

    hilo_seq_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: one pending op, identified by the absolute cycle it must commit in.
    bit          pend = 1'b0;
    int          commit_at = 0;
    logic [2:0]  p_op = 3'd0;
    logic [31:0] p_a = 32'd0, p_b = 32'd0;
    logic [31:0] ref_hi = 32'd0, ref_lo = 32'd0;

    // HI/LO unit stub, fed only by the DUT's unit_* outputs.
    logic [31:0] u_hi = 32'd0, u_lo = 32'd0;

    typedef struct { int c; logic [1:0] op; logic sin; bit dz; } ev_t;
    ev_t evq[$];
    int  stall_seen = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        int          wen_off;   // commit offset from accept, -1 when no write
        int          dz_off;    // div_zero offset from accept, -1 when none
        logic [1:0]  uop;
        logic        sin;
        logic [31:0] hi, lo;
    } vec_t;

    function automatic logic [63:0] unit_calc(input logic [1:0] uop, input logic sin,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] p;
        p = {hi, lo};
        case (uop)
            2'b00: p[63:32] = a;
            2'b01: p[31:0]  = a;
            2'b10: p = sin ? {{32{a[31]}}, a} * {{32{b[31]}}, b} : {32'd0, a} * {32'd0, b};
            default: begin
                if (sin) begin
                    p[31:0]  = $signed(a) / $signed(b);
                    p[63:32] = $signed(a) % $signed(b);
                end else begin
                    p[31:0]  = a / b;
                    p[63:32] = a % b;
                end
            end
        endcase
        return p;
    endfunction

    always @(posedge clk) begin
        logic [63:0] r;
        if (m.unit_write_en) begin
            r = unit_calc(m.unit_op, m.unit_sin, m.unit_in_1, m.unit_in_2, u_hi, u_lo);
            u_hi <= r[63:32];
            u_lo <= r[31:0];
        end
    end

    function automatic void ref_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            3'd0: ref_hi = a;
            3'd1: ref_lo = a;
            3'd2: begin p = {32'd0, a} * {32'd0, b}; {ref_hi, ref_lo} = p; end
            3'd3: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; {ref_hi, ref_lo} = p; end
            3'd4: begin ref_lo = a / b; ref_hi = a % b; end
            default: begin ref_lo = $signed(a) / $signed(b); ref_hi = $signed(a) % $signed(b); end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_outputs(input bit rd);
        bit in_commit, is_div, exp_wen, exp_dz;
        in_commit = pend && (cyc == commit_at);
        is_div    = (p_op == 3'd4) || (p_op == 3'd5);
        exp_wen   = in_commit && !(is_div && p_b == 32'd0);
        exp_dz    = in_commit && is_div && p_b == 32'd0;
        chk("req_ready", m.req_ready, !pend);
        chk("busy", m.busy, pend);
        chk("stall", m.stall, rd && pend);
        chk("unit_write_en", m.unit_write_en, exp_wen);
        chk("div_zero", m.div_zero, exp_dz);
        if (exp_wen) begin
            chk("unit_op", m.unit_op, (p_op < 3'd2) ? p_op[1:0] : 2'((p_op >> 1) + 3'd1));
            chk("unit_sin", m.unit_sin, (p_op >= 3'd2) && p_op[0]);
            chk("unit_in_1", m.unit_in_1, p_a);
            chk("unit_in_2", m.unit_in_2, p_b);
        end
        chk("hi", u_hi, ref_hi);
        chk("lo", u_lo, ref_lo);
        if (m.unit_write_en || m.div_zero)
            evq.push_back('{c: cyc, op: m.unit_op, sin: m.unit_sin, dz: m.div_zero});
        if (m.stall) stall_seen++;
        if (exp_wen) ref_exec(p_op, p_a, p_b);
    endtask

    task automatic model_update(input bit v, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input bit fl);
        if (pend) begin
            if (cyc == commit_at) pend = 1'b0;
            else if (fl) pend = 1'b0;
        end else if (v && op <= 3'd5) begin
            pend = 1'b1;
            p_op = op;
            p_a = a;
            p_b = b;
            commit_at = cyc + 1 + ((op < 3'd2) ? 0 : (op < 3'd4) ? MULT_LAT : DIV_LAT);
        end
        cyc++;
    endtask

    task automatic step(input bit v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit fl, input bit rd);
        @(negedge clk);
        m.req_valid = v;
        m.req_op    = op;
        m.req_a     = a;
        m.req_b     = b;
        m.flush     = fl;
        m.rd_req    = rd;
        #1;
        check_outputs(rd);
        model_update(v, op, a, b, fl);
    endtask

    task automatic drain(input bit rd);
        int n = 0;
        while (pend && n < 80) begin
            step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, rd);
            n++;
        end
        if (pend) chk("drain_timeout", 1, 0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, rd);
    endtask

    vec_t vecs[8];

    initial begin
        int t;
        vecs[0] = '{3'd2, 32'hFFFFFFFF, 32'd2, 5, -1, 2'b10, 1'b0, 32'h1, 32'hFFFFFFFE};
        vecs[1] = '{3'd5, 32'hFFFFFFF9, 32'd2, 33, -1, 2'b11, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[2] = '{3'd4, 32'h10, 32'd0, -1, 33, 2'b11, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{3'd0, 32'hA, 32'd0, 1, -1, 2'b00, 1'b0, 32'hA, 32'hFFFFFFFD};
        vecs[4] = '{3'd1, 32'hB, 32'd0, 1, -1, 2'b01, 1'b0, 32'hA, 32'hB};
        vecs[5] = '{3'd3, 32'hFFFFFFFE, 32'd3, 5, -1, 2'b10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[6] = '{3'd4, 32'd7, 32'd2, 33, -1, 2'b11, 1'b0, 32'h1, 32'h3};
        vecs[7] = '{3'd7, 32'h5, 32'h6, -1, -1, 2'b00, 1'b0, 32'h1, 32'h3};

        m.req_valid = 1'b0; m.req_op = 3'd0; m.req_a = 32'd0; m.req_b = 32'd0;
        m.flush = 1'b0; m.rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", m.req_ready, 1);
        chk("rst_busy", m.busy, 0);
        chk("rst_wen", m.unit_write_en, 0);
        chk("rst_div_zero", m.div_zero, 0);
        chk("rst_unit_op", {m.unit_sin, m.unit_op}, 0);
        chk("rst_unit_in", {m.unit_in_1, m.unit_in_2}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Table: one op at a time, commit timing and resulting HI/LO per entry.
        for (int i = 0; i < 8; i++) begin
            evq.delete();
            t = cyc;
            step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            drain(1'b0);
            chk($sformatf("vec%0d_events", i), evq.size(), (vecs[i].wen_off >= 0 || vecs[i].dz_off >= 0) ? 1 : 0);
            if (evq.size() > 0) begin
                chk($sformatf("vec%0d_offset", i), evq[0].c - t,
                    (vecs[i].wen_off >= 0) ? vecs[i].wen_off : vecs[i].dz_off);
                chk($sformatf("vec%0d_dz", i), evq[0].dz, vecs[i].dz_off >= 0);
                if (vecs[i].wen_off >= 0) begin
                    chk($sformatf("vec%0d_uop", i), evq[0].op, vecs[i].uop);
                    chk($sformatf("vec%0d_sin", i), evq[0].sin, vecs[i].sin);
                end
            end
            chk($sformatf("vec%0d_hi", i), u_hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), u_lo, vecs[i].lo);
        end

        // DIV with rd_req held: stalled for the whole WAIT plus COMMIT.
        evq.delete();
        stall_seen = 0;
        t = cyc;
        step(1'b1, 3'd5, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
        drain(1'b1);
        chk("div_stall_cycles", stall_seen, DIV_LAT + 1);
        chk("div_commit_at", (evq.size() > 0) ? evq[0].c - t : -1, DIV_LAT + 1);

        // Flush two cycles into a MULT, then an MTLO that commits right away.
        evq.delete();
        t = cyc;
        step(1'b1, 3'd3, 32'd9, 32'd9, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b1, 3'd1, 32'h1234, 32'd0, 1'b0, 1'b0);
        drain(1'b0);
        chk("flush_events", evq.size(), 1);
        chk("flush_mtlo_at", (evq.size() > 0) ? evq[0].c - t : -1, 4);
        chk("flush_mtlo_op", (evq.size() > 0) ? evq[0].op : 2'b11, 2'b01);

        // Asynchronous reset between edges in the middle of a DIV.
        evq.delete();
        step(1'b1, 3'd5, 32'd100, 32'd7, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_ready", m.req_ready, 1);
        chk("areset_busy", m.busy, 0);
        chk("areset_wen", m.unit_write_en, 0);
        chk("areset_unit_in_1", m.unit_in_1, 0);
        @(negedge clk);
        reset = 1'b0;
        pend = 1'b0;
        for (int i = 0; i < DIV_LAT + 4; i++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("areset_no_write", evq.size(), 0);

        // req_valid held across MTHI, MTLO, then an illegal op.
        evq.delete();
        t = cyc;
        step(1'b1, 3'd0, 32'hA, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'hB, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'hB, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd7, 32'hC, 32'd0, 1'b0, 1'b0);
        step(1'b1, 3'd7, 32'hC, 32'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("b2b_events", evq.size(), 2);
        if (evq.size() == 2) begin
            chk("b2b_mthi_at", evq[0].c - t, 1);
            chk("b2b_mthi_op", evq[0].op, 2'b00);
            chk("b2b_mtlo_at", evq[1].c - t, 3);
            chk("b2b_mtlo_op", evq[1].op, 2'b01);
        end
        chk("b2b_hi", u_hi, 32'hA);
        chk("b2b_lo", u_lo, 32'hB);

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rb;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
            step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), $urandom(), rb,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
